align_fifo: RTL and testbench

Elastic buffer between `align_s2p` and the downstream compute consumer. It captures each full-width word that `align_s2p` assembles and holds it until the consumer accepts it through a valid/ready handshake. It absorbs consumer stalls, exposes fill level and almost-full for upstream throttling, and flags any word lost because the upstream producer has no backpressure.

---
 rtl/align_pkg.sv | 12 +
 rtl/align_fifo_mem.sv | 25 ++
 rtl/align_fifo.sv | 87 ++++++++
 tb/tb_align_fifo.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/align_pkg.sv
// Shared defaults and helpers for the align_* datapath blocks.
package align_pkg;

    localparam int unsigned ALIGN_DATA_BIT   = 256;
    localparam int unsigned ALIGN_FIFO_DEPTH = 4;

    // Width needed to hold an occupancy of 0..depth inclusive.
    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/align_fifo_mem.sv
// Storage array for align_fifo: one synchronous write port, one asynchronous read port.
module align_fifo_mem #(
    parameter int unsigned DATA_BIT = 256,
    parameter int unsigned DEPTH    = 4
) (
    input  logic                        clk,
    input  logic                        we,
    input  logic [$clog2(DEPTH)-1:0]    waddr,
    input  logic [DATA_BIT-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0]    raddr,
    output logic [DATA_BIT-1:0]         rdata
);

    logic [DATA_BIT-1:0] mem [DEPTH];

    // Contents are intentionally not reset so this can map onto an SRAM macro.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/align_fifo.sv
// Show-ahead elastic buffer between align_s2p and the compute consumer, with sticky overflow flag.
module align_fifo
    import align_pkg::*;
#(
    parameter int unsigned DATA_BIT = ALIGN_DATA_BIT,
    parameter int unsigned DEPTH    = ALIGN_FIFO_DEPTH,
    parameter int unsigned AFULL_TH = 3
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic [DATA_BIT-1:0]         idata,
    input  logic                        idata_valid,
    output logic                        idata_ready,
    output logic [DATA_BIT-1:0]         odata,
    output logic                        odata_valid,
    input  logic                        odata_ready,
    output logic [cnt_w(DEPTH)-1:0]     count,
    output logic                        afull,
    output logic                        drop
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = cnt_w(DEPTH);

    logic [PTR_W-1:0]    wptr;
    logic [PTR_W-1:0]    rptr;
    logic [CNT_W-1:0]    count_nxt;
    logic [DATA_BIT-1:0] rdata;
    logic                push;
    logic                pop;

    // Handshakes qualify only on registered flags, so no input reaches an output combinationally.
    assign push = idata_valid && idata_ready;
    assign pop  = odata_valid && odata_ready;

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
        endcase
    end

    // Status flags are registered from the next occupancy so they line up with count.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr        <= '0;
            rptr        <= '0;
            count       <= '0;
            idata_ready <= 1'b1;
            odata_valid <= 1'b0;
            afull       <= 1'b0;
            drop        <= 1'b0;
        end else begin
            if (push) begin
                wptr <= wptr + PTR_W'(1);
            end
            if (pop) begin
                rptr <= rptr + PTR_W'(1);
            end
            count       <= count_nxt;
            idata_ready <= (count_nxt != CNT_W'(DEPTH));
            odata_valid <= (count_nxt != '0);
            afull       <= (count_nxt >= CNT_W'(AFULL_TH));
            if (idata_valid && !idata_ready) begin
                drop <= 1'b1;
            end
        end
    end

    align_fifo_mem #(
        .DATA_BIT (DATA_BIT),
        .DEPTH    (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wptr),
        .wdata (idata),
        .raddr (rptr),
        .rdata (rdata)
    );

    // Gate the uninitialised array so odata reads zero out of reset and when empty.
    assign odata = odata_valid ? rdata : '0;

endmodule

// File: tb/tb_align_fifo.sv
// Directed self-checking bench for align_fifo with default parameters.
module tb_align_fifo;

    localparam int unsigned DW = 256;

    logic          clk;
    logic          rstn;
    logic [DW-1:0] idata;
    logic          idata_valid;
    logic          idata_ready;
    logic [DW-1:0] odata;
    logic          odata_valid;
    logic          odata_ready;
    logic [2:0]    count;
    logic          afull;
    logic          drop;

    int checks = 0;
    int errors = 0;

    align_fifo #(.DATA_BIT(DW), .DEPTH(4), .AFULL_TH(3)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .idata       (idata),
        .idata_valid (idata_valid),
        .idata_ready (idata_ready),
        .odata       (odata),
        .odata_valid (odata_valid),
        .odata_ready (odata_ready),
        .count       (count),
        .afull       (afull),
        .drop        (drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idata_valid = 1'b0;
        odata_ready = 1'b0;
        idata       = '0;
        @(negedge clk);
        rstn = 1'b0;
        #2;
        rstn = 1'b1;
        step();
    endtask

    function automatic logic [DW-1:0] rep(input logic [3:0] nib);
        return {64{nib}};
    endfunction

    logic [DW-1:0] words [4];

    initial begin
        rstn        = 1'b0;
        idata       = '0;
        idata_valid = 1'b0;
        odata_ready = 1'b0;
        words[0] = rep(4'hA);
        words[1] = rep(4'hB);
        words[2] = rep(4'hC);
        words[3] = rep(4'hD);
        #12;

        chk("rst_ready", DW'(idata_ready), DW'(1));
        chk("rst_valid", DW'(odata_valid), DW'(0));
        chk("rst_odata", odata, '0);
        chk("rst_count", DW'(count), DW'(0));
        chk("rst_afull", DW'(afull), DW'(0));
        chk("rst_drop",  DW'(drop), DW'(0));
        rstn = 1'b1;
        step();

        // Fill with consumer stalled.
        for (int i = 0; i < 4; i++) begin
            idata       = words[i];
            idata_valid = 1'b1;
            step();
            chk("fill_count", DW'(count), DW'(i + 1));
            chk("fill_afull", DW'(afull), DW'((i + 1) >= 3));
            chk("fill_ready", DW'(idata_ready), DW'((i + 1) < 4));
            chk("fill_head", odata, words[0]);
        end

        // Overflow attempt.
        idata = rep(4'hF);
        step();
        idata_valid = 1'b0;
        chk("ovf_drop", DW'(drop), DW'(1));
        chk("ovf_count", DW'(count), DW'(4));
        step();
        chk("ovf_drop_sticky", DW'(drop), DW'(1));

        // Drain in order.
        odata_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_valid", DW'(odata_valid), DW'(1));
            chk("drain_data", odata, words[i]);
            step();
        end
        chk("drain_empty", DW'(odata_valid), DW'(0));
        chk("drain_count", DW'(count), DW'(0));
        chk("drain_drop", DW'(drop), DW'(1));

        // Streaming with consumer always ready.
        do_reset();
        chk("strm_drop0", DW'(drop), DW'(0));
        odata_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            idata       = DW'(i);
            idata_valid = 1'b1;
            step();
            chk("strm_count", DW'(count), DW'(1));
            chk("strm_data", odata, DW'(i));
        end
        idata_valid = 1'b0;
        step();
        chk("strm_empty", DW'(count), DW'(0));
        chk("strm_drop", DW'(drop), DW'(0));

        // Simultaneous push/pop holding count at 2.
        odata_ready = 1'b0;
        idata_valid = 1'b1;
        idata = DW'(100);
        step();
        idata = DW'(101);
        step();
        chk("sim_pre_count", DW'(count), DW'(2));
        odata_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            idata = DW'(102 + k);
            step();
            chk("sim_count", DW'(count), DW'(2));
            chk("sim_head", odata, DW'(101 + k));
        end
        idata_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk("sim_tail", odata, DW'(108 + k));
            step();
        end
        chk("sim_empty", DW'(odata_valid), DW'(0));

        // Reset mid-operation with 3 words stored and drop set.
        odata_ready = 1'b0;
        idata_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            idata = words[i % 4];
            step();
        end
        idata_valid = 1'b0;
        odata_ready = 1'b1;
        step();
        odata_ready = 1'b0;
        chk("mid_count3", DW'(count), DW'(3));
        chk("mid_drop1", DW'(drop), DW'(1));
        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("mid_valid", DW'(odata_valid), DW'(0));
        chk("mid_count", DW'(count), DW'(0));
        chk("mid_drop", DW'(drop), DW'(0));
        chk("mid_ready", DW'(idata_ready), DW'(1));
        #2;
        rstn = 1'b1;
        step();
        idata_valid = 1'b1;
        idata = rep(4'h1);
        step();
        idata = rep(4'h5);
        step();
        idata_valid = 1'b0;
        chk("post_first", odata, rep(4'h1));
        odata_ready = 1'b1;
        step();
        chk("post_second", odata, rep(4'h5));
        step();
        chk("post_empty", DW'(odata_valid), DW'(0));

        // One assembled 256-bit word from four 64-bit beats, first beat in the LSBs.
        do_reset();
        idata = {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}};
        idata_valid = 1'b1;
        step();
        idata_valid = 1'b0;
        step();
        chk("chain_count", DW'(count), DW'(1));
        chk("chain_word", odata, {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}});
        odata_ready = 1'b1;
        step();
        chk("chain_popped", DW'(odata_valid), DW'(0));
        chk("chain_count0", DW'(count), DW'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
